alu16: RTL and testbench

- 16-bit two's-complement ALU with the six-control-bit zx/nx/zy/ny/f/no scheme.
- Result is registered: one clock after the operands and controls are presented, it appears on out with zr and ng status flags.
- Serves as the arithmetic/logic core of the CPU datapath, feeding the A/D registers and jump logic.

---
 rtl/alu16_if.sv | 27 ++
 rtl/alu16.sv | 46 ++++
 tb/tb_alu16.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/alu16_if.sv
// Operand, control and result bundle for the alu16 core.
// The master drives operands/controls; the ALU (slave) returns the result.
interface alu16_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             zx;
    logic             nx;
    logic             zy;
    logic             ny;
    logic             f;
    logic             no;
    logic [WIDTH-1:0] out;
    logic             zr;
    logic             ng;

    modport master (
        output x, y, zx, nx, zy, ny, f, no,
        input  out, zr, ng
    );

    modport slave (
        input  x, y, zx, nx, zy, ny, f, no,
        output out, zr, ng
    );
endinterface

// File: rtl/alu16.sv
// 16-bit zx/nx/zy/ny/f/no ALU with a single registered output stage.
// Flags are computed from the same result word that is captured into out.
module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    alu16_if.slave bus
);
    logic [WIDTH-1:0] xa, xb, ya, yb, r, res;
    logic [WIDTH-1:0] out_d, out_q;
    logic             zr_d, zr_q;
    logic             ng_d, ng_q;

    always_comb begin
        xa = bus.zx ? '0 : bus.x;
        xb = bus.nx ? ~xa : xa;
        ya = bus.zy ? '0 : bus.y;
        yb = bus.ny ? ~ya : ya;
        // carry-out is dropped: the sum wraps silently
        r   = bus.f ? (xb + yb) : (xb & yb);
        res = bus.no ? ~r : r;
    end

    always_comb begin
        out_d = res;
        zr_d  = (res == '0);
        ng_d  = res[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            zr_q  <= 1'b1;
            ng_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            zr_q  <= zr_d;
            ng_q  <= ng_d;
        end
    end

    assign bus.out = out_q;
    assign bus.zr  = zr_q;
    assign bus.ng  = ng_q;
endmodule

// File: tb/tb_alu16.sv
// Scoreboard bench for alu16: driver pushes expected results,
// a monitor pops and compares one cycle after each issue.
module tb_alu16;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [17:0] sb_q[$];

    alu16_if #(.WIDTH(16)) bus ();

    alu16 #(.WIDTH(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [5:0]  c
    );
        logic [15:0] a, b, r;
        a = c[5] ? 16'h0 : x;
        if (c[4]) a = ~a;
        b = c[3] ? 16'h0 : y;
        if (c[2]) b = ~b;
        r = c[1] ? 16'(a + b) : (a & b);
        if (c[0]) r = ~r;
        return r;
    endfunction

    task automatic issue(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [5:0]  c,
        input logic [15:0] exp
    );
        @(negedge clk);
        bus.x  = x;
        bus.y  = y;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = c;
        sb_q.push_back({exp, exp == 16'h0, exp[15]});
    endtask

    task automatic chk_reset(input string tag);
        checks++;
        if (bus.out !== 16'h0 || bus.zr !== 1'b1 || bus.ng !== 1'b0) begin
            errors++;
            $display("FAIL %s: out=%h zr=%b ng=%b, want out=0000 zr=1 ng=0",
                     tag, bus.out, bus.zr, bus.ng);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk_reset({tag, "_async"});
        @(negedge clk);
        chk_reset({tag, "_hold"});
        rst_n = 1'b1;
    endtask

    // Monitor: every captured cycle with a pending expectation is compared.
    always @(posedge clk) begin
        #1;
        if (rst_n && sb_q.size() > 0) begin
            logic [17:0] e;
            e = sb_q.pop_front();
            checks++;
            if ({bus.out, bus.zr, bus.ng} !== e) begin
                errors++;
                $display("FAIL result: out=%h zr=%b ng=%b, want out=%h zr=%b ng=%b",
                         bus.out, bus.zr, bus.ng, e[17:2], e[1], e[0]);
            end
        end
    end

    typedef struct {
        logic [5:0]  c;
        logic [15:0] exp;
    } vec_t;

    vec_t ref_tab[14];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        bus.x  = '0;
        bus.y  = '0;
        {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = 6'b0;

        ref_tab[0]  = '{6'b101010, 16'h0000};
        ref_tab[1]  = '{6'b111111, 16'h0001};
        ref_tab[2]  = '{6'b111010, 16'hFFFF};
        ref_tab[3]  = '{6'b001100, 16'h0004};
        ref_tab[4]  = '{6'b110000, 16'h0001};
        ref_tab[5]  = '{6'b001101, 16'hFFFB};
        ref_tab[6]  = '{6'b001111, 16'hFFFC};
        ref_tab[7]  = '{6'b011111, 16'h0005};
        ref_tab[8]  = '{6'b001110, 16'h0003};
        ref_tab[9]  = '{6'b000010, 16'h0005};
        ref_tab[10] = '{6'b010011, 16'h0003};
        ref_tab[11] = '{6'b000111, 16'hFFFD};
        ref_tab[12] = '{6'b000000, 16'h0000};
        ref_tab[13] = '{6'b010101, 16'h0005};

        repeat (2) @(negedge clk);
        pulse_reset("reset0");
        issue(16'd4, 16'd1, 6'b000010, 16'd5);

        for (int i = 0; i < 14; i++)
            issue(16'd4, 16'd1, ref_tab[i].c, ref_tab[i].exp);

        for (int c = 0; c < 64; c++)
            issue(16'd4, 16'd1, 6'(c), model(16'd4, 16'd1, 6'(c)));

        issue(16'h7FFF, 16'h0001, 6'b000010, 16'h8000);
        issue(16'd5, 16'd5, 6'b010011, 16'h0000);

        issue(16'h8000, 16'h1234, 6'b011111, 16'h8001);
        issue(16'h8000, 16'h1234, 6'b001110, 16'h7FFF);
        issue(16'h8000, 16'h1234, 6'b001111, 16'h8000);

        pulse_reset("reset_mid");

        for (int i = 0; i < 10000; i++) begin
            logic [15:0] rx, ry;
            logic [5:0]  rc;
            if ($urandom_range(0, 299) == 0) pulse_reset("reset_rand");
            rx = 16'($urandom);
            ry = 16'($urandom);
            rc = 6'($urandom);
            issue(rx, ry, rc, model(rx, ry, rc));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d, want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
